pipe_addsub: RTL and testbench



---
 rtl/pipe_addsub_pkg.sv | 10 +
 rtl/pipe_addsub_slice.sv | 26 ++
 rtl/pipe_addsub.sv | 140 ++++++++++++++
 tb/tb_pipe_addsub.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_addsub_pkg.sv
// Shared definitions for the pipelined adder/subtractor datapath.
// The mode encoding is shared by every block that drives or decodes the mode input.
package alu_defs;

    typedef enum logic {
        MODE_ADD = 1'b0,
        MODE_SUB = 1'b1
    } mode_e;

endpackage

// File: rtl/pipe_addsub_slice.sv
// Combinational CHUNK-bit slice of the split carry chain.
// Reports the carry into its top bit so the last slice can derive signed overflow.
module addsub_slice #(
    parameter int CHUNK = 4
) (
    input  logic [CHUNK-1:0] x,
    input  logic [CHUNK-1:0] y,
    input  logic             ci,
    output logic [CHUNK-1:0] sum,
    output logic             co,
    output logic             c_msb,
    output logic             zero
);

    logic [CHUNK:0] total_s;

    // Slice add; the carry into the top bit falls out of x^y^sum at that bit.
    always_comb begin
        total_s = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, ci};
        sum     = total_s[CHUNK-1:0];
        co      = total_s[CHUNK];
        c_msb   = x[CHUNK-1] ^ y[CHUNK-1] ^ total_s[CHUNK-1];
        zero    = (total_s[CHUNK-1:0] == {CHUNK{1'b0}});
    end

endmodule

// File: rtl/pipe_addsub.sv
// Pipelined WIDTH-bit adder/subtractor: one CHUNK-bit carry slice per stage,
// valid/ready handshake with a single global advance enable.
module pipe_addsub
    import alu_defs::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cf,
    output logic             of,
    output logic             zf
);

    localparam int STAGES = WIDTH / CHUNK;
    localparam int LAST   = STAGES - 1;

    logic             en_s;
    logic             sub_s;
    mode_e            mode_s;

    logic             valid_r    [STAGES];
    logic [WIDTH-1:0] sum_r      [STAGES];
    logic             carry_r    [STAGES];
    logic             zero_r     [STAGES];
    logic [WIDTH-1:0] opa_r      [STAGES];
    logic [WIDTH-1:0] opb_r      [STAGES];
    logic             of_r;

    logic             valid_in_s [STAGES];
    logic [WIDTH-1:0] sum_in_s   [STAGES];
    logic             carry_in_s [STAGES];
    logic             zero_in_s  [STAGES];
    logic [WIDTH-1:0] opa_in_s   [STAGES];
    logic [WIDTH-1:0] opb_in_s   [STAGES];

    logic [CHUNK-1:0] slice_sum_s  [STAGES];
    logic             slice_co_s   [STAGES];
    logic             slice_cmsb_s [STAGES];
    logic             slice_zero_s [STAGES];
    logic [WIDTH-1:0] sum_nxt_s    [STAGES];
    logic             zero_nxt_s   [STAGES];

    // Stage inputs: stage 0 takes the ports (b and cin pre-inverted for SUB), others the previous stage.
    always_comb begin
        int prev;
        prev   = 0;
        mode_s = mode_e'(mode);
        sub_s  = (mode_s == MODE_SUB);
        en_s   = !valid_r[LAST] || out_ready;
        for (int i = 0; i < STAGES; i++) begin
            prev = (i > 0) ? i - 1 : 0;
            if (i == 0) begin
                valid_in_s[i] = in_valid;
                sum_in_s[i]   = {WIDTH{1'b0}};
                carry_in_s[i] = cin ^ sub_s;
                zero_in_s[i]  = 1'b1;
                opa_in_s[i]   = a;
                opb_in_s[i]   = b ^ {WIDTH{sub_s}};
            end else begin
                valid_in_s[i] = valid_r[prev];
                sum_in_s[i]   = sum_r[prev];
                carry_in_s[i] = carry_r[prev];
                zero_in_s[i]  = zero_r[prev];
                opa_in_s[i]   = opa_r[prev];
                opb_in_s[i]   = opb_r[prev];
            end
        end
    end

    for (genvar g = 0; g < STAGES; g++) begin : g_slice
        addsub_slice #(
            .CHUNK (CHUNK)
        ) u_slice (
            .x     (opa_in_s[g][g*CHUNK +: CHUNK]),
            .y     (opb_in_s[g][g*CHUNK +: CHUNK]),
            .ci    (carry_in_s[g]),
            .sum   (slice_sum_s[g]),
            .co    (slice_co_s[g]),
            .c_msb (slice_cmsb_s[g]),
            .zero  (slice_zero_s[g])
        );
    end

    // Merge each slice result into the partial sum and the running zero flag.
    always_comb begin
        for (int i = 0; i < STAGES; i++) begin
            sum_nxt_s[i]                   = sum_in_s[i];
            sum_nxt_s[i][i*CHUNK +: CHUNK] = slice_sum_s[i];
            zero_nxt_s[i]                  = zero_in_s[i] & slice_zero_s[i];
        end
    end

    // Pipeline registers: all stages advance together on en; data is only reloaded for valid entries.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_r[i] <= 1'b0;
                sum_r[i]   <= {WIDTH{1'b0}};
                carry_r[i] <= 1'b0;
                zero_r[i]  <= 1'b0;
                opa_r[i]   <= {WIDTH{1'b0}};
                opb_r[i]   <= {WIDTH{1'b0}};
            end
            of_r <= 1'b0;
        end else if (en_s) begin
            for (int i = 0; i < STAGES; i++) begin
                valid_r[i] <= valid_in_s[i];
                if (valid_in_s[i]) begin
                    sum_r[i]   <= sum_nxt_s[i];
                    carry_r[i] <= slice_co_s[i];
                    zero_r[i]  <= zero_nxt_s[i];
                    opa_r[i]   <= opa_in_s[i];
                    opb_r[i]   <= opb_in_s[i];
                end
            end
            if (valid_in_s[LAST]) begin
                of_r <= slice_cmsb_s[LAST] ^ slice_co_s[LAST];
            end
        end
    end

    assign in_ready  = en_s;
    assign out_valid = valid_r[LAST];
    assign s         = sum_r[LAST];
    assign cf        = carry_r[LAST];
    assign zf        = zero_r[LAST];
    assign of        = of_r;

endmodule

// File: tb/tb_pipe_addsub.sv
// Directed bench for pipe_addsub at 32/4 and 8/8, with an arithmetic reference
// and a cycle-level handshake model for streaming and backpressure.
module tb_pipe_addsub;

    localparam int S = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid, in_ready, cin, mode, out_valid, out_ready, cf, of, zf;
    logic [31:0] a, b, s;
    logic        in_valid8, in_ready8, cin8, mode8, out_valid8, out_ready8, cf8, of8, zf8;
    logic [7:0]  a8, b8, s8;

    int          checks = 0;
    int          errors = 0;
    int          acc = 0;
    int          pops = 0;
    logic        m_valid [S];
    logic [34:0] m_res   [S];

    always #5 clk = ~clk;

    pipe_addsub #(.WIDTH(32), .CHUNK(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .mode(mode),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cf(cf), .of(of), .zf(zf)
    );

    pipe_addsub #(.WIDTH(8), .CHUNK(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .a(a8), .b(b8), .cin(cin8), .mode(mode8),
        .out_valid(out_valid8), .out_ready(out_ready8),
        .s(s8), .cf(cf8), .of(of8), .zf(zf8)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Returns {zf, of, cf, s}; overflow from operand/result signs.
    function automatic logic [34:0] ref_op(input logic [31:0] ra, input logic [31:0] rb,
                                           input logic rcin, input logic rmode);
        logic [31:0] bb;
        logic        c0;
        logic [32:0] full;
        logic        ovf;
        bb   = rmode ? ~rb : rb;
        c0   = rmode ? ~rcin : rcin;
        full = {1'b0, ra} + {1'b0, bb} + {32'd0, c0};
        ovf  = (ra[31] == bb[31]) && (full[31] != ra[31]);
        return {(full[31:0] == 32'd0), ovf, full[32], full[31:0]};
    endfunction

    // One clock of the 32-bit DUT, checked against the handshake model.
    task automatic cyc(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                       input logic icin, input logic imode, input logic ordy);
        logic        en;
        logic        stall;
        logic [31:0] prev_s;
        in_valid = iv; a = ia; b = ib; cin = icin; mode = imode; out_ready = ordy;
        #1;
        en     = !m_valid[S-1] || ordy;
        stall  = m_valid[S-1] && !ordy;
        prev_s = s;
        if (!rst) begin
            chk("in_ready", 64'(in_ready), 64'(en));
            if (iv && en) acc++;
            if (out_valid && ordy) pops++;
        end
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < S; i++) m_valid[i] = 1'b0;
        end else if (en) begin
            for (int i = S - 1; i > 0; i--) begin
                m_valid[i] = m_valid[i-1];
                m_res[i]   = m_res[i-1];
            end
            m_valid[0] = iv;
            m_res[0]   = ref_op(ia, ib, icin, imode);
        end
        #1;
        chk("out_valid", 64'(out_valid), 64'(m_valid[S-1]));
        if (m_valid[S-1]) chk("result", 64'({zf, of, cf, s}), 64'(m_res[S-1]));
        if (stall && !rst) chk("s_hold", 64'(s), 64'(prev_s));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic directed(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                            input logic icin, input logic imode, input logic [31:0] es,
                            input logic ecf, input logic eof, input logic ezf);
        int lat;
        cyc(1'b1, ia, ib, icin, imode, 1'b1);
        lat = 1;
        while (!out_valid && lat < 20) begin
            cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            lat++;
        end
        chk({tag, "_latency"}, 64'(lat), 64'd8);
        chk({tag, "_s"},  64'(s),  64'(es));
        chk({tag, "_cf"}, 64'(cf), 64'(ecf));
        chk({tag, "_of"}, 64'(of), 64'(eof));
        chk({tag, "_zf"}, 64'(zf), 64'(ezf));
        idle(1);
    endtask

    initial begin
        logic [31:0] ra, rb, rr;
        int          nout, first, last, seen;

        for (int i = 0; i < S; i++) begin
            m_valid[i] = 1'b0;
            m_res[i]   = 35'd0;
        end
        in_valid = 1'b1; a = 32'h1234_5678; b = 32'h0F0F_0F0F; cin = 1'b1; mode = 1'b0; out_ready = 1'b1;
        in_valid8 = 1'b1; a8 = 8'h11; b8 = 8'h22; cin8 = 1'b0; mode8 = 1'b0; out_ready8 = 1'b1;

        // Reset held for three cycles with input offered.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_out_valid", 64'(out_valid), 64'd0);
            chk("rst_s", 64'(s), 64'd0);
            chk("rst_flags", 64'({cf, of, zf}), 64'd0);
            chk("rst_out_valid8", 64'(out_valid8), 64'd0);
        end
        rst = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 64'd1);

        directed("add_wrap",  32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed("sub_ovf",   32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
        directed("sub_borrow", 32'h0000_0005, 32'h0000_0005, 1'b1, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        directed("sub_zero",  32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
        directed("add_ovf",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
        directed("add_cin",   32'h0000_000F, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0010, 1'b0, 1'b0, 1'b0);

        // Streaming: 20 back-to-back operations.
        nout = 0; first = -1; last = -1;
        for (int k = 0; k < 30; k++) begin
            ra = $urandom(); rb = $urandom(); rr = $urandom();
            if (k < 20) cyc(1'b1, ra, rb, rr[0], rr[1], 1'b1);
            else        cyc(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
            if (out_valid) begin
                if (first < 0) first = k;
                last = k;
                nout++;
            end
        end
        chk("stream_count", 64'(nout), 64'd20);
        chk("stream_first", 64'(first), 64'd7);
        chk("stream_span", 64'(last - first), 64'd19);

        // Full pipe, then five cycles of backpressure with input still offered.
        for (int k = 0; k < 10; k++) begin
            ra = $urandom(); rb = $urandom(); rr = $urandom();
            cyc(1'b1, ra, rb, rr[0], rr[1], 1'b1);
        end
        for (int k = 0; k < 5; k++) begin
            ra = $urandom(); rb = $urandom(); rr = $urandom();
            cyc(1'b1, ra, rb, rr[0], rr[1], 1'b0);
        end
        for (int k = 0; k < 40; k++) begin
            ra = $urandom(); rb = $urandom(); rr = $urandom();
            cyc(rr[2], ra, rb, rr[0], rr[1], rr[3] | rr[4]);
        end
        idle(12);
        chk("balance", 64'(pops), 64'(acc));

        // Reset with four operations in flight.
        for (int k = 0; k < 4; k++) begin
            ra = $urandom(); rb = $urandom();
            cyc(1'b1, ra, rb, 1'b0, 1'b0, 1'b1);
        end
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            idle(1);
            if (out_valid) seen++;
        end
        chk("flush_no_output", 64'(seen), 64'd0);

        // Single-stage instance: latency 1.
        chk("w8_idle", 64'(out_valid8), 64'd0);
        a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; mode8 = 1'b0; in_valid8 = 1'b1;
        @(posedge clk);
        #1;
        a8 = 8'h00; mode8 = 1'b1;
        chk("w8_add_valid", 64'(out_valid8), 64'd1);
        chk("w8_add_s", 64'(s8), 64'h80);
        chk("w8_add_flags", 64'({cf8, of8, zf8}), 64'b010);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        chk("w8_sub_valid", 64'(out_valid8), 64'd1);
        chk("w8_sub_s", 64'(s8), 64'hFF);
        chk("w8_sub_flags", 64'({cf8, of8, zf8}), 64'b000);
        @(posedge clk);
        #1;
        chk("w8_drained", 64'(out_valid8), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
